// File: rtl/trap_ctrl.sv
// ============================================================================
// trap_ctrl -- machine-mode trap sequencer
//
// Purpose:
//   Accepts one request at a time from the core: a synchronous exception, an
//   mret, or an enabled machine interrupt. It then stalls the pipeline and
//   waits for it to drain. It commits the trap or return to the CSR file with
//   a single-cycle strobe and finally hands a PC redirect to fetch.
//
//   Sequence:  IDLE -> DRAIN (until pipe_idle) -> COMMIT (1 cycle)
//              -> REDIRECT (until redirect_ready) -> IDLE
//
// Ports:
//   ctrl_clk, ctrl_reset       clock, asynchronous active-high reset
//   exc_valid/exc_cause/exc_pc exception request (sampled in IDLE only)
//   mret_req                   mret request (sampled in IDLE only)
//   irq_ext/irq_timer/irq_soft raw machine interrupt pending lines
//   mie_en                     {MEIE, MTIE, MSIE} per-line enables
//   ctrl_mie                   global interrupt enable (mstatus.MIE)
//   irq_pc                     PC saved as mepc when an interrupt is taken
//   pipe_idle                  older instructions retired, CSR writes visible
//   mtvec, mepc                live CSR values used to form the redirect PC
//   redirect_ready             fetch accepts the redirect
//   stall                      high whenever the sequencer is not IDLE
//   ctrl_trap/ctrl_mret        one-cycle commit strobe, mret qualifier
//   trap_pc/trap_info          mepc value and {is_interrupt, cause[3:0]}
//   redirect_valid/redirect_pc redirect request and target to fetch
// ============================================================================
module trap_ctrl (
    input  logic        ctrl_clk,
    input  logic        ctrl_reset,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic        mret_req,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_soft,
    input  logic [2:0]  mie_en,
    input  logic        ctrl_mie,
    input  logic [31:0] irq_pc,
    input  logic        pipe_idle,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        redirect_ready,
    output logic        stall,
    output logic        ctrl_trap,
    output logic        ctrl_mret,
    output logic [31:0] trap_pc,
    output logic [4:0]  trap_info,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    // Machine interrupt cause codes.
    localparam logic [3:0] CAUSE_M_SOFT  = 4'd3;
    localparam logic [3:0] CAUSE_M_TIMER = 4'd7;
    localparam logic [3:0] CAUSE_M_EXT   = 4'd11;

    // mtvec MODE field value that selects vectored interrupt dispatch.
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_COMMIT,
        S_REDIRECT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Captured description of the request being sequenced.
    logic        r_is_mret;
    logic        r_is_irq;
    logic [3:0]  r_cause;
    logic [31:0] r_pc;

    // Request selection results, meaningful only while IDLE.
    logic [2:0]  w_irq_pend;
    logic        w_irq_take;
    logic        w_accept;
    logic        w_cap_mret;
    logic        w_cap_irq;
    logic [3:0]  w_cap_cause;
    logic [31:0] w_cap_pc;

    // Redirect target pieces.
    logic [31:0] w_vec_base;
    logic [31:0] w_vec_off;

    // ------------------------------------------------------------------------
    // Request arbitration: exception > mret > interrupt.
    // Within interrupts: external > software > timer (mie_en is {E, T, S}).
    // ------------------------------------------------------------------------
    assign w_irq_pend = {irq_ext, irq_timer, irq_soft} & mie_en;
    assign w_irq_take = ctrl_mie && (|w_irq_pend);

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_accept    = 1'b0;
        w_cap_mret  = 1'b0;
        w_cap_irq   = 1'b0;
        w_cap_cause = 4'd0;
        w_cap_pc    = 32'd0;
        if (exc_valid) begin
            w_accept    = 1'b1;
            w_cap_cause = exc_cause;
            w_cap_pc    = exc_pc;
        end else if (mret_req) begin
            w_accept    = 1'b1;
            w_cap_mret  = 1'b1;
        end else if (w_irq_take) begin
            w_accept    = 1'b1;
            w_cap_irq   = 1'b1;
            w_cap_pc    = irq_pc;
            if (w_irq_pend[2]) begin
                w_cap_cause = CAUSE_M_EXT;
            end else if (w_irq_pend[0]) begin
                w_cap_cause = CAUSE_M_SOFT;
            end else begin
                w_cap_cause = CAUSE_M_TIMER;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples pre-edge values, independent of statement order.
    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pipe_idle) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Capture registers: loaded only when IDLE accepts a request, and held
    // through the remainder of the sequence.
    // ------------------------------------------------------------------------
    // NOTE: these are control state, not storage arrays, so they are reset;
    // a reset mid-sequence must not leave a stale cause/pc behind.
    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_is_mret <= 1'b0;
            r_is_irq  <= 1'b0;
            r_cause   <= 4'd0;
            r_pc      <= 32'd0;
        end else if ((r_state == S_IDLE) && w_accept) begin
            r_is_mret <= w_cap_mret;
            r_is_irq  <= w_cap_irq;
            r_cause   <= w_cap_cause;
            r_pc      <= w_cap_pc;
        end
    end

    // ------------------------------------------------------------------------
    // Redirect target. mtvec/mepc are read live: the CSR file has already
    // absorbed the commit by the time the sequencer reaches REDIRECT.
    // Vectored offset arithmetic wraps modulo 2^32.
    // ------------------------------------------------------------------------
    assign w_vec_base = {mtvec[31:2], 2'b00};
    assign w_vec_off  = {26'd0, r_cause, 2'b00};

    // ------------------------------------------------------------------------
    // Outputs: decoded from state and capture registers. In IDLE (and so
    // immediately on reset) every output is zero.
    // ------------------------------------------------------------------------
    always_comb begin
        stall          = (r_state != S_IDLE);
        ctrl_trap      = 1'b0;
        ctrl_mret      = 1'b0;
        trap_pc        = 32'd0;
        trap_info      = 5'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        case (r_state)
            S_COMMIT: begin
                ctrl_trap = 1'b1;
                ctrl_mret = r_is_mret;
                // An mret writes neither mepc nor mcause.
                if (!r_is_mret) begin
                    trap_pc   = r_pc;
                    trap_info = {r_is_irq, r_cause};
                end
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                if (r_is_mret) begin
                    redirect_pc = mepc;
                end else if (r_is_irq && (mtvec[1:0] == MTVEC_VECTORED)) begin
                    redirect_pc = w_vec_base + w_vec_off;
                end else begin
                    redirect_pc = w_vec_base;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// ============================================================================
// tb_trap_ctrl -- directed self-checking bench for trap_ctrl
//
// Expected commits and redirect targets are pushed to a scoreboard queue when
// a request is driven and popped when the DUT raises ctrl_trap. Outputs are
// sampled 1 time unit after the rising edge; inputs change at the same point.
// ============================================================================
module tb_trap_ctrl;

    logic        ctrl_clk;
    logic        ctrl_reset;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        mret_req;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_soft;
    logic [2:0]  mie_en;
    logic        ctrl_mie;
    logic [31:0] irq_pc;
    logic        pipe_idle;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        redirect_ready;
    logic        stall;
    logic        ctrl_trap;
    logic        ctrl_mret;
    logic [31:0] trap_pc;
    logic [4:0]  trap_info;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    trap_ctrl dut (
        .ctrl_clk       (ctrl_clk),
        .ctrl_reset     (ctrl_reset),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .mret_req       (mret_req),
        .irq_ext        (irq_ext),
        .irq_timer      (irq_timer),
        .irq_soft       (irq_soft),
        .mie_en         (mie_en),
        .ctrl_mie       (ctrl_mie),
        .irq_pc         (irq_pc),
        .pipe_idle      (pipe_idle),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .redirect_ready (redirect_ready),
        .stall          (stall),
        .ctrl_trap      (ctrl_trap),
        .ctrl_mret      (ctrl_mret),
        .trap_pc        (trap_pc),
        .trap_info      (trap_info),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial ctrl_clk = 1'b0;
    always #5 ctrl_clk = ~ctrl_clk;

    int cyc = 0;
    always @(posedge ctrl_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        mret;
        logic [31:0] pc;
        logic [4:0]  info;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ctrl_clk);
        #1;
    endtask

    task automatic push(input logic m, input logic [31:0] pc, input logic [4:0] info,
                        input logic [31:0] rpc);
        exp_t e;
        e.mret = m;
        e.pc   = pc;
        e.info = info;
        e.rpc  = rpc;
        sb_q.push_back(e);
    endtask

    task automatic clear_reqs();
        exc_valid = 1'b0;
        mret_req  = 1'b0;
        irq_ext   = 1'b0;
        irq_timer = 1'b0;
        irq_soft  = 1'b0;
    endtask

    // Clock the request in, drop it, and confirm the sequence has started.
    task automatic launch(input string tag);
        tick();
        clear_reqs();
        check({tag, "_stall_on"}, {31'd0, stall}, 32'd1);
    endtask

    // Wait (bounded) for the commit strobe; lat counts edges after launch.
    task automatic wait_commit(input string tag, output int lat);
        lat = 0;
        while ((ctrl_trap !== 1'b1) && (lat < 40)) begin
            check({tag, "_stall_hold"}, {31'd0, stall}, 32'd1);
            tick();
            lat++;
        end
        check({tag, "_commit_seen"}, {31'd0, ctrl_trap}, 32'd1);
    endtask

    // Compare the commit cycle against the scoreboard, step into REDIRECT and
    // check the target; optionally complete the handshake.
    task automatic finish_commit(input string tag, input bit handshake);
        exp_t e;
        check({tag, "_sb_nonempty"}, (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        check({tag, "_mret"},  {31'd0, ctrl_mret}, {31'd0, e.mret});
        check({tag, "_pc"},    trap_pc,            e.pc);
        check({tag, "_info"},  {27'd0, trap_info}, {27'd0, e.info});
        tick();
        check({tag, "_trap_1cyc"}, {31'd0, ctrl_trap},      32'd0);
        check({tag, "_rvalid"},    {31'd0, redirect_valid}, 32'd1);
        check({tag, "_rpc"},       redirect_pc,             e.rpc);
        if (handshake) begin
            tick();
            check({tag, "_stall_off"}, {31'd0, stall},          32'd0);
            check({tag, "_rv_off"},    {31'd0, redirect_valid}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, {31'd0, stall},          32'd0);
        check({tag, "_trap"},  {31'd0, ctrl_trap},      32'd0);
        check({tag, "_mret"},  {31'd0, ctrl_mret},      32'd0);
        check({tag, "_tpc"},   trap_pc,                 32'd0);
        check({tag, "_tinfo"}, {27'd0, trap_info},      32'd0);
        check({tag, "_rv"},    {31'd0, redirect_valid}, 32'd0);
        check({tag, "_rpc"},   redirect_pc,             32'd0);
    endtask

    initial begin
        int   lat;
        int   c0;
        logic [31:0] held_rpc;

        ctrl_reset     = 1'b1;
        clear_reqs();
        exc_cause      = 4'd0;
        exc_pc         = 32'd0;
        mie_en         = 3'b000;
        ctrl_mie       = 1'b0;
        irq_pc         = 32'd0;
        pipe_idle      = 1'b1;
        mtvec          = 32'd0;
        mepc           = 32'd0;
        redirect_ready = 1'b1;

        tick();
        check_all_zero("rst");
        ctrl_reset = 1'b0;
        tick();
        check_all_zero("post_rst");

        // --- Exception, mtvec MODE=1 but exceptions are never vectored ---
        mtvec     = 32'h8000_0001;
        exc_valid = 1'b1;
        exc_cause = 4'd2;
        exc_pc    = 32'h0000_0100;
        push(1'b0, 32'h100, 5'h02, 32'h8000_0000);
        launch("exc");
        wait_commit("exc", lat);
        check("exc_latency", lat, 32'd1);
        finish_commit("exc", 1'b1);

        // --- Vectored timer interrupt ---
        mtvec     = 32'h0000_1001;
        irq_pc    = 32'h0000_0204;
        mie_en    = 3'b010;
        ctrl_mie  = 1'b1;
        irq_timer = 1'b1;
        push(1'b0, 32'h204, 5'h17, 32'h0000_101C);
        launch("tmr");
        wait_commit("tmr", lat);
        finish_commit("tmr", 1'b1);

        // --- Same interrupt with the global enable off: must be ignored ---
        ctrl_mie  = 1'b0;
        irq_timer = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mie_off_stall", {31'd0, stall}, 32'd0);
        end
        clear_reqs();
        ctrl_mie = 1'b1;

        // --- Everything at once: exception wins, not vectored ---
        mie_en    = 3'b111;
        exc_valid = 1'b1;
        exc_cause = 4'd5;
        exc_pc    = 32'h0000_0300;
        mret_req  = 1'b1;
        irq_ext   = 1'b1;
        irq_timer = 1'b1;
        irq_soft  = 1'b1;
        push(1'b0, 32'h300, 5'h05, 32'h0000_1000);
        launch("prio");
        wait_commit("prio", lat);
        finish_commit("prio", 1'b1);

        // --- mret alone ---
        mepc     = 32'h0000_4440;
        mret_req = 1'b1;
        push(1'b1, 32'h0, 5'h00, 32'h0000_4440);
        launch("mret");
        wait_commit("mret", lat);
        finish_commit("mret", 1'b1);

        // --- All three interrupts enabled: external, vectored cause 11 ---
        irq_pc    = 32'h0000_0400;
        irq_ext   = 1'b1;
        irq_timer = 1'b1;
        irq_soft  = 1'b1;
        push(1'b0, 32'h400, 5'h1B, 32'h0000_102C);
        launch("ext");
        wait_commit("ext", lat);
        finish_commit("ext", 1'b1);

        // --- External masked off: software beats timer ---
        mie_en    = 3'b011;
        irq_ext   = 1'b1;
        irq_timer = 1'b1;
        irq_soft  = 1'b1;
        push(1'b0, 32'h400, 5'h13, 32'h0000_100C);
        launch("sw");
        wait_commit("sw", lat);
        finish_commit("sw", 1'b1);

        // --- Vectored target wraps modulo 2^32 ---
        mie_en  = 3'b111;
        mtvec   = 32'hFFFF_FFF1;
        irq_ext = 1'b1;
        push(1'b0, 32'h400, 5'h1B, 32'h0000_001C);
        launch("wrap");
        wait_commit("wrap", lat);
        finish_commit("wrap", 1'b1);

        // --- Drain 5 cycles (new requests ignored), then backpressure ---
        mtvec     = 32'h0000_2000;
        pipe_idle = 1'b0;
        exc_valid = 1'b1;
        exc_cause = 4'd4;
        exc_pc    = 32'h0000_0500;
        push(1'b0, 32'h500, 5'h04, 32'h0000_2000);
        launch("drain");
        mret_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_no_trap", {31'd0, ctrl_trap}, 32'd0);
            check("drain_stall",   {31'd0, stall},     32'd1);
            tick();
        end
        mret_req       = 1'b0;
        pipe_idle      = 1'b1;
        redirect_ready = 1'b0;
        wait_commit("drain", lat);
        finish_commit("drain", 1'b0);
        held_rpc = redirect_pc;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_rv_hold",  {31'd0, redirect_valid}, 32'd1);
            check("bp_rpc_hold", redirect_pc,             held_rpc);
            check("bp_no_trap",  {31'd0, ctrl_trap},      32'd0);
        end
        redirect_ready = 1'b1;
        tick();
        check("bp_stall_off", {31'd0, stall}, 32'd0);

        // --- Back-to-back: second commit 4 cycles after the first ---
        exc_valid = 1'b1;
        exc_cause = 4'd1;
        exc_pc    = 32'h0000_0600;
        push(1'b0, 32'h600, 5'h01, 32'h0000_2000);
        launch("b2b_a");
        wait_commit("b2b_a", lat);
        c0 = cyc;
        finish_commit("b2b_a", 1'b0);
        tick();
        check("b2b_idle", {31'd0, stall}, 32'd0);
        exc_valid = 1'b1;
        exc_cause = 4'd6;
        exc_pc    = 32'h0000_0700;
        push(1'b0, 32'h700, 5'h06, 32'h0000_2000);
        launch("b2b_b");
        wait_commit("b2b_b", lat);
        check("b2b_gap", cyc - c0, 32'd4);
        finish_commit("b2b_b", 1'b1);

        // --- Reset while in DRAIN ---
        pipe_idle = 1'b0;
        exc_valid = 1'b1;
        exc_cause = 4'd3;
        exc_pc    = 32'h0000_0800;
        launch("rdrain");
        ctrl_reset = 1'b1;
        #1;
        check_all_zero("rdrain");
        tick();
        ctrl_reset = 1'b0;
        pipe_idle  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdrain_no_trap", {31'd0, ctrl_trap}, 32'd0);
        end

        // --- Reset while in REDIRECT ---
        redirect_ready = 1'b0;
        exc_valid      = 1'b1;
        exc_cause      = 4'd7;
        exc_pc         = 32'h0000_0900;
        push(1'b0, 32'h900, 5'h07, 32'h0000_2000);
        launch("rredir");
        wait_commit("rredir", lat);
        finish_commit("rredir", 1'b0);
        ctrl_reset = 1'b1;
        #1;
        check_all_zero("rredir");
        tick();
        ctrl_reset     = 1'b0;
        redirect_ready = 1'b1;
        tick();
        check_all_zero("rredir_idle");

        // --- Clean sequence after reset ---
        mtvec     = 32'h0000_3001;
        irq_pc    = 32'h0000_0A00;
        mie_en    = 3'b001;
        irq_soft  = 1'b1;
        push(1'b0, 32'hA00, 5'h13, 32'h0000_300C);
        launch("clean");
        wait_commit("clean", lat);
        check("clean_latency", lat, 32'd1);
        finish_commit("clean", 1'b1);

        check("sb_drained", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer that drives the trap side of the CSR file: ctrl_trap, ctrl_mret, trap_pc and trap_info. It accepts synchronous exceptions, mret requests and masked machine interrupts from the core. It stalls and drains the pipeline, commits the trap or return to the CSR file for exactly one cycle, then issues a PC redirect to the fetch stage. It sits between the execute/writeback stages, the CSR file and fetch.

## Interface
- No parameters.
- ctrl_clk  in  1  clock; all state updates on posedge.
- ctrl_reset  in  1  reset; asynchronous, active-high.
- exc_valid  in  1  exception request pulse from execute; sampled only in IDLE.
- exc_cause  in  4  exception code (mcause[3:0]).
- exc_pc  in  32  PC of the faulting instruction.
- mret_req  in  1  mret request pulse; sampled only in IDLE.
- irq_ext, irq_timer, irq_soft  in  1 each  raw machine external/timer/software pending lines.
- mie_en  in  3  {MEIE, MTIE, MSIE} from the mie CSR.
- ctrl_mie  in  1  global interrupt enable (mstatus.MIE) from the CSR file.
- irq_pc  in  32  PC of the next instruction to execute; saved as mepc on an interrupt.
- pipe_idle  in  1  all older in-flight instructions have retired and their CSR writes are visible.
- mtvec  in  32  current mtvec CSR value.
- mepc  in  32  current mepc CSR value.
- redirect_ready  in  1  fetch accepts the redirect.
- stall  out  1  freeze issue and squash younger instructions; high whenever the state is not IDLE.
- ctrl_trap  out  1  one-cycle commit strobe to the CSR file.
- ctrl_mret  out  1  qualifies ctrl_trap as an mret; only ever high together with ctrl_trap.
- trap_pc  out  32  value written to mepc.
- trap_info  out  5  {is_interrupt, cause[3:0]}.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  32  new fetch PC.

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT. All outputs are registered or decoded from state plus captured registers.
- IDLE: evaluates requests in priority order and captures kind, cause and pc, then moves to DRAIN. Priority order:
  - exc_valid: cause = exc_cause, is_interrupt = 0, pc = exc_pc.
  - mret_req: kind = mret.
  - Interrupt, considered only if ctrl_mie = 1 and at least one enabled line is pending: external (cause 11) > software (cause 3) > timer (cause 7). is_interrupt = 1, pc = irq_pc.
  - Unselected requests in the same cycle are dropped. The pipeline squashes and replays them; level interrupts re-assert on their own.
- DRAIN: hold until pipe_idle = 1, then go to COMMIT. exc_valid, mret_req and the irq lines are ignored in DRAIN, COMMIT and REDIRECT.
- COMMIT: exactly one cycle. ctrl_trap = 1 and ctrl_mret = (kind == mret). trap_pc and trap_info are driven from the captured values, and are 0 for an mret. Next state is REDIRECT.
- REDIRECT: redirect_valid = 1, with redirect_pc sampled combinationally from the mtvec/mepc inputs. These CSRs are already updated after COMMIT.
  - mret: redirect_pc = mepc.
  - Trap with mtvec[1:0] == 1 and is_interrupt = 1: redirect_pc = {mtvec[31:2],2'b00} + (cause << 2).
  - Any other trap: redirect_pc = {mtvec[31:2],2'b00}.
  - The sum is 32-bit modulo 2^32; wrap is not flagged.
  - On the cycle redirect_valid && redirect_ready the state returns to IDLE.
- Reset, including mid-sequence: state goes to IDLE and every captured register clears. No ctrl_trap pulse is emitted for an interrupted sequence.

## Timing
- Reset values: stall = 0, ctrl_trap = 0, ctrl_mret = 0, trap_pc = 0, trap_info = 0, redirect_valid = 0, redirect_pc = 0.
- A request accepted at edge T gives stall = 1 from T+1.
- With pipe_idle already 1: DRAIN lasts 1 cycle (T+1), COMMIT is at T+2, and redirect_valid rises at T+3. Minimum request-to-redirect latency is 3 cycles.
- Each extra cycle of pipe_idle = 0 adds one cycle of DRAIN.
- ctrl_trap is never high for more than one consecutive cycle. At most one commit occurs per sequence.
- redirect_valid stays high and redirect_pc stays stable while redirect_ready = 0.
- stall drops in the cycle after the redirect handshake. IDLE may accept a new request in that same cycle.
- Back-to-back traps are possible: a second request accepted in the first IDLE cycle after a sequence yields a commit 4 cycles after the previous commit.

## Test plan
- Exception: exc_valid = 1, exc_cause = 2, exc_pc = 0x100, mtvec = 0x8000_0001, pipe_idle = 1. Expect ctrl_trap pulse at T+2 with trap_pc = 0x100 and trap_info = 0x02, ctrl_mret = 0, then redirect_pc = 0x8000_0000.
- Vectored interrupt: irq_timer = 1, mie_en = 3'b010, ctrl_mie = 1, irq_pc = 0x204, mtvec = 0x1001. Expect trap_info = 0x17, trap_pc = 0x204, redirect_pc = 0x101C. Repeat with ctrl_mie = 0: no stall.
- Priority: exc_valid, mret_req and all three irqs asserted together. Expect an exception commit. Then mret alone gives ctrl_trap = ctrl_mret = 1 and redirect_pc = mepc. Then irq_ext + irq_soft + irq_timer with all enabled gives cause 11.
- Drain and backpressure: pipe_idle held 0 for 5 cycles, then redirect_ready held 0 for 3 cycles. Expect no ctrl_trap until pipe_idle rises, stall continuous, and redirect_valid/redirect_pc held stable.
- Reset mid-sequence: assert ctrl_reset in DRAIN and in REDIRECT. Expect all outputs 0 immediately (asynchronous), no ctrl_trap pulse, and a clean new sequence after release.
